// File: rtl/ysyx_24080006_pkg.sv
// ============================================================================
// ysyx_24080006_pkg : shared ALU / MDU operation encodings for decoder and EX
// Revision: 1.0
// ============================================================================
`default_nettype none

package ysyx_24080006_pkg;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_XOR   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_AND   = 5'd4,
    ALU_SLL   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_SLT   = 5'd8,
    ALU_SLTU  = 5'd9,
    ALU_EQ    = 5'd10,
    ALU_NE    = 5'd11,
    ALU_LT    = 5'd12,
    ALU_GE    = 5'd13,
    ALU_LTU   = 5'd14,
    ALU_GEU   = 5'd15,
    ALU_PASSB = 5'd16
  } alu_op_e;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef struct packed {
    logic    mdu_enable;
    mdu_op_e mdu_op;
  } mdu_set_t;

endpackage

`default_nettype wire

// File: rtl/ysyx_24080006_muldiv_core.sv
// ============================================================================
// ysyx_24080006_muldiv_core : radix-2 iterative multiply/divide, fixed latency
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_24080006_muldiv_core
  import ysyx_24080006_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        mdu_valid_i,
  input  mdu_set_t    mdu_set,
  input  logic [31:0] mdu_a,
  input  logic [31:0] mdu_b,
  output logic        mdu_valid_o,
  output logic [31:0] mdu_c
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [5:0] c_steps = 6'd32;

  state_e      r_state;
  logic [5:0]  r_cnt;
  mdu_op_e     r_op;
  logic        r_neg_a;
  logic        r_neg_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_b;
  logic        r_valid;
  logic [31:0] r_c;

  logic        w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic [31:0] w_mag_a, w_mag_b;
  logic [32:0] w_sum;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [63:0] w_prod, w_prod_s;
  logic [31:0] w_result;

  // Operand sign handling at capture time
  always_comb begin
    w_sgn_a = (mdu_set.mdu_op == MDU_MULH) || (mdu_set.mdu_op == MDU_MULHSU) ||
              (mdu_set.mdu_op == MDU_DIV)  || (mdu_set.mdu_op == MDU_REM);
    w_sgn_b = (mdu_set.mdu_op == MDU_MULH) || (mdu_set.mdu_op == MDU_DIV) ||
              (mdu_set.mdu_op == MDU_REM);
    w_neg_a = w_sgn_a & mdu_a[31];
    w_neg_b = w_sgn_b & mdu_b[31];
    w_mag_a = w_neg_a ? (32'd0 - mdu_a) : mdu_a;
    w_mag_b = w_neg_b ? (32'd0 - mdu_b) : mdu_b;
  end

  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
  assign w_rem_sh = {r_hi, r_lo[31]};
  assign w_ge     = w_rem_sh >= {1'b0, r_b};
  assign w_sub    = w_rem_sh[31:0] - r_b;
  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = (r_neg_a ^ r_neg_b) ? (64'd0 - w_prod) : w_prod;

  // Sign fix-up; only signed divide-by-zero needs an override, overflow falls out naturally
  always_comb begin
    w_result = 32'd0;
    case (r_op)
      MDU_MUL:    w_result = w_prod_s[31:0];
      MDU_MULH,
      MDU_MULHSU,
      MDU_MULHU:  w_result = w_prod_s[63:32];
      MDU_DIV:    w_result = (r_b == 32'd0) ? 32'hFFFF_FFFF :
                             ((r_neg_a ^ r_neg_b) ? (32'd0 - r_lo) : r_lo);
      MDU_DIVU:   w_result = r_lo;
      MDU_REM:    w_result = r_neg_a ? (32'd0 - r_hi) : r_hi;
      MDU_REMU:   w_result = r_hi;
      default:    w_result = 32'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_op    <= MDU_MUL;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_b     <= 32'd0;
      r_valid <= 1'b0;
      r_c     <= 32'd0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mdu_valid_i && mdu_set.mdu_enable) begin
            r_op    <= mdu_set.mdu_op;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_hi    <= 32'd0;
            r_lo    <= w_mag_a;
            r_b     <= w_mag_b;
            r_cnt   <= c_steps;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != 6'd0) begin
            r_cnt <= r_cnt - 6'd1;
            if (r_op[2]) begin
              r_hi <= w_ge ? w_sub : w_rem_sh[31:0];
              r_lo <= {r_lo[30:0], w_ge};
            end else begin
              r_hi <= w_sum[32:1];
              r_lo <= {w_sum[0], r_lo[31:1]};
            end
          end else begin
            r_c     <= w_result;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mdu_valid_o = r_valid;
  assign mdu_c       = r_c;

endmodule

`default_nettype wire

// File: rtl/ysyx_24080006_arith_unit.sv
// ============================================================================
// ysyx_24080006_arith_unit : RV32IM EX datapath, inline ALU plus iterative MDU
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_24080006_arith_unit
  import ysyx_24080006_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  alu_op_e     alu_op,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [31:0] alu_c,
  input  logic        mdu_valid_i,
  input  mdu_set_t    mdu_set,
  input  logic [31:0] mdu_a,
  input  logic [31:0] mdu_b,
  output logic        mdu_valid_o,
  output logic [31:0] mdu_c
);

  logic w_lt, w_ltu, w_eq;

  assign w_lt  = $signed(alu_a) < $signed(alu_b);
  assign w_ltu = alu_a < alu_b;
  assign w_eq  = alu_a == alu_b;

  always_comb begin
    alu_c = 32'd0;
    case (alu_op)
      ALU_ADD:   alu_c = alu_a + alu_b;
      ALU_SUB:   alu_c = alu_a - alu_b;
      ALU_XOR:   alu_c = alu_a ^ alu_b;
      ALU_OR:    alu_c = alu_a | alu_b;
      ALU_AND:   alu_c = alu_a & alu_b;
      ALU_SLL:   alu_c = alu_a << alu_b[4:0];
      ALU_SRL:   alu_c = alu_a >> alu_b[4:0];
      ALU_SRA:   alu_c = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      ALU_SLT,
      ALU_LT:    alu_c = {31'd0, w_lt};
      ALU_SLTU,
      ALU_LTU:   alu_c = {31'd0, w_ltu};
      ALU_EQ:    alu_c = {31'd0, w_eq};
      ALU_NE:    alu_c = {31'd0, ~w_eq};
      ALU_GE:    alu_c = {31'd0, ~w_lt};
      ALU_GEU:   alu_c = {31'd0, ~w_ltu};
      ALU_PASSB: alu_c = alu_b;
      default:   alu_c = 32'd0;
    endcase
  end

  ysyx_24080006_muldiv_core u_mdu (
    .clock       (clock),
    .reset       (reset),
    .mdu_valid_i (mdu_valid_i),
    .mdu_set     (mdu_set),
    .mdu_a       (mdu_a),
    .mdu_b       (mdu_b),
    .mdu_valid_o (mdu_valid_o),
    .mdu_c       (mdu_c)
  );

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24080006_arith_unit.sv
// ============================================================================
// tb_ysyx_24080006_arith_unit : self-checking bench for ALU and MDU
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_24080006_arith_unit;
  import ysyx_24080006_pkg::*;

  logic        clock;
  logic        reset;
  alu_op_e     alu_op;
  logic [31:0] alu_a, alu_b, alu_c;
  logic        mdu_valid_i;
  mdu_set_t    mdu_set;
  logic [31:0] mdu_a, mdu_b;
  logic        mdu_valid_o;
  logic [31:0] mdu_c;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [31:0] exp_q[$];

  ysyx_24080006_arith_unit dut (
    .clock       (clock),
    .reset       (reset),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_c       (alu_c),
    .mdu_valid_i (mdu_valid_i),
    .mdu_set     (mdu_set),
    .mdu_a       (mdu_a),
    .mdu_b       (mdu_b),
    .mdu_valid_o (mdu_valid_o),
    .mdu_c       (mdu_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic test_reset;
    reset = 1'b0;
    #1;
    n_checks++;
    if (mdu_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", mdu_valid_o); end
    n_checks++;
    if (mdu_c !== 32'd0) begin n_fail++; $display("FAIL reset_c got %h want 0", mdu_c); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_alu;
    alu_op_e     ops[10];
    logic [31:0] as[10], bs[10], es[10];
    ops[0] = ALU_SUB;   as[0] = 32'd5;          bs[0] = 32'd7;          es[0] = 32'hFFFF_FFFE;
    ops[1] = ALU_SRA;   as[1] = 32'h8000_0000;  bs[1] = 32'd4;          es[1] = 32'hF800_0000;
    ops[2] = ALU_SLTU;  as[2] = 32'd1;          bs[2] = 32'hFFFF_FFFF;  es[2] = 32'd1;
    ops[3] = ALU_LT;    as[3] = 32'hFFFF_FFFF;  bs[3] = 32'd1;          es[3] = 32'd1;
    ops[4] = ALU_GEU;   as[4] = 32'd1;          bs[4] = 32'hFFFF_FFFF;  es[4] = 32'd0;
    ops[5] = ALU_ADD;   as[5] = 32'hFFFF_FFFF;  bs[5] = 32'd1;          es[5] = 32'd0;
    ops[6] = ALU_SLL;   as[6] = 32'd1;          bs[6] = 32'd33;         es[6] = 32'd2;
    ops[7] = ALU_SRL;   as[7] = 32'h8000_0000;  bs[7] = 32'd4;          es[7] = 32'h0800_0000;
    ops[8] = ALU_PASSB; as[8] = 32'd3;          bs[8] = 32'h1234_5000;  es[8] = 32'h1234_5000;
    ops[9] = alu_op_e'(5'd31); as[9] = 32'd9;   bs[9] = 32'd9;          es[9] = 32'd0;
    for (int i = 0; i < 10; i++) begin
      alu_op = ops[i]; alu_a = as[i]; alu_b = bs[i];
      #1;
      n_checks++;
      if (alu_c !== es[i]) begin
        n_fail++;
        $display("FAIL alu[%0d] op=%0d got %h want %h", i, ops[i], alu_c, es[i]);
      end
    end
  endtask

  // Drives one MDU op, scoreboards the result and checks latency and pulse width
  task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name, input int hold);
    int d;
    bit seen;
    logic [31:0] e;
    @(negedge clock);
    mdu_valid_i = 1'b1;
    mdu_set.mdu_enable = 1'b1;
    mdu_set.mdu_op = op;
    mdu_a = a; mdu_b = b;
    exp_q.push_back(exp);
    d = cyc;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      if (mdu_valid_o) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout no mdu_valid_o within 60 cycles", name);
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if (mdu_c !== e) begin n_fail++; $display("FAIL %s result got %h want %h", name, mdu_c, e); end
      n_checks++;
      if (cyc - d !== 34) begin n_fail++; $display("FAIL %s latency got %0d want 34", name, cyc - d); end
    end
    if (hold == 0) mdu_valid_i = 1'b0;
    @(negedge clock);
    n_checks++;
    if (mdu_valid_o !== 1'b0) begin n_fail++; $display("FAIL %s pulse_width valid still %b want 0", name, mdu_valid_o); end
    mdu_valid_i = 1'b0;
  endtask

  task automatic test_mul;
    run_op(MDU_MUL,    32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFEB, "mul",    0);
    run_op(MDU_MULH,   32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, "mulh",   0);
    run_op(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu", 0);
    run_op(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu", 0);
  endtask

  task automatic test_div;
    run_op(MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div",  0);
    run_op(MDU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem",  0);
    run_op(MDU_DIVU, 32'd100,       32'd7, 32'd14,        "divu", 0);
    run_op(MDU_REMU, 32'd100,       32'd7, 32'd2,         "remu", 0);
  endtask

  task automatic test_corner;
    run_op(MDU_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, "div_by0",     0);
    run_op(MDU_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, "div_neg_by0", 0);
    run_op(MDU_REMU, 32'd9,         32'd0,         32'd9,         "remu_by0",    0);
    run_op(MDU_REM,  32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, "rem_by0",     0);
    run_op(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf",     0);
    run_op(MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf",     0);
  endtask

  task automatic test_handshake;
    int pulses;
    run_op(MDU_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1, "hold_done", 1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mdu_valid_o) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL hold_retrigger extra pulses got %0d want 0", pulses); end
  endtask

  task automatic test_back_to_back;
    int t1, t2;
    bit seen;
    logic [31:0] e;
    @(negedge clock);
    mdu_valid_i = 1'b1;
    mdu_set.mdu_enable = 1'b1;
    mdu_set.mdu_op = MDU_MUL;
    mdu_a = 32'd1234; mdu_b = 32'd5678;
    exp_q.push_back(32'd7006652);
    exp_q.push_back(32'd333);
    t1 = 0; t2 = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      if (mdu_valid_o) begin seen = 1'b1; t1 = cyc; end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL b2b_first timeout"); end
    else begin
      e = exp_q.pop_front();
      n_checks++;
      if (mdu_c !== e) begin n_fail++; $display("FAIL b2b_first result got %h want %h", mdu_c, e); end
    end
    mdu_set.mdu_op = MDU_DIVU;
    mdu_a = 32'd1000; mdu_b = 32'd3;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      if (mdu_valid_o) begin seen = 1'b1; t2 = cyc; end
    end
    mdu_valid_i = 1'b0;
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL b2b_second timeout"); exp_q.delete(); end
    else begin
      e = exp_q.pop_front();
      n_checks++;
      if (mdu_c !== e) begin n_fail++; $display("FAIL b2b_second result got %h want %h", mdu_c, e); end
      n_checks++;
      if (t2 - t1 !== 35) begin n_fail++; $display("FAIL b2b_spacing got %0d want 35", t2 - t1); end
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    mdu_valid_i = 1'b1;
    mdu_set.mdu_enable = 1'b1;
    mdu_set.mdu_op = MDU_MUL;
    mdu_a = 32'd3; mdu_b = 32'd3;
    @(negedge clock);
    mdu_valid_i = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if (mdu_valid_o !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b want 0", mdu_valid_o); end
    n_checks++;
    if (mdu_c !== 32'd0) begin n_fail++; $display("FAIL midreset_c got %h want 0", mdu_c); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    run_op(MDU_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, "after_reset", 0);
  endtask

  initial begin
    alu_op = ALU_ADD; alu_a = 32'd0; alu_b = 32'd0;
    mdu_valid_i = 1'b0;
    mdu_set.mdu_enable = 1'b0;
    mdu_set.mdu_op = MDU_MUL;
    mdu_a = 32'd0; mdu_b = 32'd0;
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_corner();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
